// File: rtl/count_snapshot_fifo.sv
// Capture stage for the binary counter: snapshots {result, count} on each trigger
// event into a small FIFO that drains to a consumer over valid/ready.
module count_snapshot_fifo #(
  parameter int COUNT_W = 6,
  parameter int DEPTH   = 4,
  parameter bit EDGE    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNT_W-1:0]       count_in,
  input  logic                     result_in,
  input  logic                     trig,
  output logic [COUNT_W:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [COUNT_W:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             trig_q_r;
  logic             overflow_r;

  logic cap_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic full_s;

  // Capture/push/pop decode; a full FIFO still accepts a capture when it pops in the same cycle
  always_comb begin
    full_s = (level_r == LW'(DEPTH));
    if (EDGE) begin
      cap_s = trig & ~trig_q_r;
    end else begin
      cap_s = trig;
    end
    pop_s  = (level_r != {LW{1'b0}}) & out_ready;
    push_s = cap_s & (~full_s | pop_s);
    drop_s = cap_s & full_s & ~pop_s;
  end

  // Storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(COUNT_W+1){1'b0}};
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      trig_q_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      trig_q_r <= trig;
      if (push_s) begin
        mem_r[wr_ptr_r] <= {result_in, count_in};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign out_data  = mem_r[rd_ptr_r];
  assign out_valid = (level_r != {LW{1'b0}});
  assign level     = level_r;
  assign full      = full_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Self-checking bench: an EDGE=1 and an EDGE=0 instance share stimulus and are
// compared every cycle against queue-based reference models.
module tb_count_snapshot_fifo;

  logic       clk;
  logic       rst;
  logic [5:0] count_in;
  logic       result_in;
  logic       trig;
  logic       out_ready;
  logic       clr_ovf;

  logic [6:0] out_data0, out_data1;
  logic       out_valid0, out_valid1;
  logic [2:0] level0, level1;
  logic       full0, full1;
  logic       overflow0, overflow1;

  int n_checks = 0;
  int n_fails  = 0;

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic       mtq0;
  logic       mov0, mov1;

  count_snapshot_fifo #(.COUNT_W(6), .DEPTH(4), .EDGE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .count_in(count_in), .result_in(result_in), .trig(trig),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .level(level0), .full(full0), .overflow(overflow0), .clr_ovf(clr_ovf)
  );

  count_snapshot_fifo #(.COUNT_W(6), .DEPTH(4), .EDGE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .count_in(count_in), .result_in(result_in), .trig(trig),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .level(level1), .full(full1), .overflow(overflow1), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference models with the current inputs, clock once, compare both DUTs
  task automatic tick();
    logic       cap0, cap1, pop0, pop1, f0, f1;
    logic [6:0] d;
    d = {result_in, count_in};
    if (!rst) begin
      q0.delete();
      q1.delete();
      mtq0 = 1'b0;
      mov0 = 1'b0;
      mov1 = 1'b0;
    end else begin
      cap0 = trig & ~mtq0;
      cap1 = trig;
      pop0 = (q0.size() != 0) && out_ready;
      pop1 = (q1.size() != 0) && out_ready;
      f0   = (q0.size() == 4);
      f1   = (q1.size() == 4);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (cap0 && (!f0 || pop0)) q0.push_back(d);
      if (cap1 && (!f1 || pop1)) q1.push_back(d);
      if (cap0 && f0 && !pop0) mov0 = 1'b1;
      else if (clr_ovf) mov0 = 1'b0;
      if (cap1 && f1 && !pop1) mov1 = 1'b1;
      else if (clr_ovf) mov1 = 1'b0;
      mtq0 = trig;
    end
    @(posedge clk);
    #1;
    check_val("level0", 32'(level0), 32'(q0.size()));
    check_val("valid0", 32'(out_valid0), 32'(q0.size() != 0));
    check_val("full0", 32'(full0), 32'(q0.size() == 4));
    check_val("ovf0", 32'(overflow0), 32'(mov0));
    if (q0.size() != 0) check_val("data0", 32'(out_data0), 32'(q0[0]));
    check_val("level1", 32'(level1), 32'(q1.size()));
    check_val("valid1", 32'(out_valid1), 32'(q1.size() != 0));
    check_val("full1", 32'(full1), 32'(q1.size() == 4));
    check_val("ovf1", 32'(overflow1), 32'(mov1));
    if (q1.size() != 0) check_val("data1", 32'(out_data1), 32'(q1[0]));
    count_in  = count_in + 6'd1;
    result_in = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b0; trig = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    count_in = 6'd0; result_in = 1'b0;
    mtq0 = 1'b0; mov0 = 1'b0; mov1 = 1'b0;
    repeat (2) tick();
    check_val("rst_data0", 32'(out_data0), 32'h0);
    check_val("rst_data1", 32'(out_data1), 32'h0);

    // Pulses at counts 3, 7, 12 with the consumer stalled, then drain
    rst = 1'b1;
    count_in = 6'd0;
    for (int i = 0; i < 14; i++) begin
      trig = (count_in == 6'd3) || (count_in == 6'd7) || (count_in == 6'd12);
      tick();
    end
    check_val("p1_level", 32'(level0), 32'd3);
    check_val("p1_head", 32'(out_data0[5:0]), 32'd3);
    trig = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check_val("p1_empty", 32'(out_valid0), 32'd0);

    // Fill then overflow; set beats clear in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trig = 1'b1; tick();
      trig = 1'b0; tick();
    end
    check_val("p2_full", 32'(full0), 32'd1);
    check_val("p2_level", 32'(level0), 32'd4);
    check_val("p2_ovf", 32'(overflow0), 32'd1);
    clr_ovf = 1'b1; tick();
    check_val("p2_clr", 32'(overflow0), 32'd0);
    trig = 1'b1; tick();
    check_val("p2_setwins", 32'(overflow0), 32'd1);
    trig = 1'b0; tick();
    check_val("p2_clr2", 32'(overflow0), 32'd0);
    clr_ovf = 1'b0;

    // Full FIFO: capture and pop together
    trig = 1'b1; out_ready = 1'b1; tick();
    trig = 1'b0; out_ready = 1'b0; tick();
    check_val("p3_level", 32'(level0), 32'd4);
    check_val("p3_ovf", 32'(overflow0), 32'd0);
    out_ready = 1'b1;
    repeat (5) tick();

    // trig held high for five cycles
    out_ready = 1'b0;
    trig = 1'b1;
    repeat (5) tick();
    trig = 1'b0; tick();
    check_val("p4_edge_level", 32'(level0), 32'd1);
    check_val("p4_lvl_level", 32'(level1), 32'd4);
    check_val("p4_lvl_ovf", 32'(overflow1), 32'd1);
    out_ready = 1'b1; clr_ovf = 1'b1;
    repeat (5) tick();
    clr_ovf = 1'b0;

    // Ten entries through the pointer wrap, then random traffic
    for (int i = 0; i < 10; i++) begin
      trig = 1'b1; tick();
      trig = 1'b0; tick();
    end
    for (int i = 0; i < 60; i++) begin
      trig      = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      clr_ovf   = ($urandom_range(0, 7) == 0);
      tick();
    end
    trig = 1'b0; out_ready = 1'b1; clr_ovf = 1'b1;
    repeat (6) tick();
    clr_ovf = 1'b0;

    // Reset with three entries queued and trig high
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig = 1'b1; tick();
      trig = 1'b0; tick();
    end
    check_val("p6_pre_level", 32'(level0), 32'd3);
    rst = 1'b0; trig = 1'b1; tick();
    check_val("p6_level", 32'(level0), 32'd0);
    check_val("p6_valid", 32'(out_valid0), 32'd0);
    check_val("p6_ovf", 32'(overflow0), 32'd0);
    rst = 1'b1; tick();
    trig = 1'b0; tick();
    check_val("p6_first_edge", 32'(level0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
